rtc_burst_reader: RTL and testbench

Read-side counterpart of the RTC control-word writer. It generates multiplexed-bus read cycles (address phase, then data phase) to the external RTC chip and fetches NUM_REGS consecutive registers starting at BASE_ADDR. It sits between the time-display/crono logic and the shared AD bus pads. Each fetched byte is presented with a one-cycle valid strobe and an index.

---
 rtl/rtc_burst_reader.sv | 99 +++++++++
 tb/tb_rtc_burst_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rtc_burst_reader.sv
// rtc_burst_reader: multiplexed-bus burst reader fetching NUM_REGS RTC registers from BASE_ADDR
module rtc_burst_reader #(
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int NUM_REGS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ADin,
  output logic       ad,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [7:0] ADout,
  output logic       ADoe,
  output logic       busy,
  output logic [7:0] dout,
  output logic [3:0] dout_idx,
  output logic       dout_valid,
  output logic       done
);
  typedef enum logic {IDLE, FRAME} state_t;
  state_t state, state_n;
  logic [4:0] cnt;
  logic [3:0] idx;
  logic last;
  assign last = idx == 4'(NUM_REGS - 1);
  // next state: accept a burst only when idle, return to idle after the last frame
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = FRAME;
    if (state == FRAME && cnt == 5'd31 && last) state_n = IDLE;
  end
  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // frame sequencer: every bus action is keyed to the in-frame cycle counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {ad, cs, wr, rd} <= 4'hF;
      ADout <= 8'hFF;
      ADoe <= 1'b0;
      busy <= 1'b0;
      dout <= 8'h00;
      dout_idx <= 4'h0;
      dout_valid <= 1'b0;
      done <= 1'b0;
      cnt <= 5'd0;
      idx <= 4'h0;
    end else begin
      dout_valid <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          busy <= 1'b1;
          cnt <= 5'd0;
          idx <= 4'h0;
        end
      end else begin
        cnt <= cnt + 5'd1;
        case (cnt)
          5'd0: {ad, cs, wr, rd} <= 4'hF;
          5'd1: ad <= 1'b0;
          5'd2: cs <= 1'b0;
          5'd3: wr <= 1'b0;
          5'd4: begin
            ADout <= BASE_ADDR + 8'(idx);
            ADoe <= 1'b1;
          end
          5'd9: wr <= 1'b1;
          5'd10: cs <= 1'b1;
          5'd11: ad <= 1'b1;
          5'd13: begin
            ADout <= 8'hFF;
            ADoe <= 1'b0;
          end
          5'd22: cs <= 1'b0;
          5'd23: rd <= 1'b0;
          5'd28: begin
            dout <= ADin;
            dout_idx <= idx;
            dout_valid <= 1'b1;
          end
          5'd29: rd <= 1'b1;
          5'd30: cs <= 1'b1;
          5'd31: begin
            if (last) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else idx <= idx + 4'h1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rtc_burst_reader.sv
// tb_rtc_burst_reader: three parameterisations driven from a step table, checked cycle by cycle against a timing model and a read scoreboard
module tb_rtc_burst_reader;
  localparam logic [7:0] BA [3] = '{8'h21, 8'hFE, 8'h21};
  localparam int NR [3] = '{3, 3, 1};
  typedef struct { logic [3:0] idx; logic [7:0] data; } rec_t;
  typedef struct { logic [2:0] mask; int len; int rp; int total; logic [11:0] exp_done; } step_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start_v [3];
  logic [7:0] ad_in_v [3];
  logic ad_v [3], cs_v [3], wr_v [3], rd_v [3], adoe_v [3], busy_v [3], valid_v [3], done_v [3];
  logic [7:0] ad_out_v [3], dout_v [3];
  logic [3:0] idx_v [3];

  int n_assert = 0;
  int n_fail = 0;
  int done_cnt [3] = '{0, 0, 0};
  int mn [3];
  bit mact [3] = '{0, 0, 0};
  rec_t sb [3][$];

  always #5 clock = ~clock;

  // RTC register contents as seen by the bench
  function automatic logic [7:0] rtc(input logic [7:0] a);
    case (a)
      8'h21: return 8'h45;
      8'h22: return 8'h30;
      8'h23: return 8'h12;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  task automatic chk(input string nm, input int g, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    logic [7:0] lat;
    rtc_burst_reader #(.BASE_ADDR(BA[g]), .NUM_REGS(NR[g])) dut (
      .clock(clock), .reset(reset), .start(start_v[g]), .ADin(ad_in_v[g]),
      .ad(ad_v[g]), .cs(cs_v[g]), .wr(wr_v[g]), .rd(rd_v[g]),
      .ADout(ad_out_v[g]), .ADoe(adoe_v[g]), .busy(busy_v[g]),
      .dout(dout_v[g]), .dout_idx(idx_v[g]), .dout_valid(valid_v[g]), .done(done_v[g])
    );
    always @(posedge clock) if (!ad_v[g] && adoe_v[g]) lat <= ad_out_v[g];
    assign ad_in_v[g] = rd_v[g] ? 8'h00 : rtc(lat);
  end

  // per-cycle model: n counts edges since accept, so cnt == n%32 and frame == n/32
  always @(posedge clock) begin
    #1;
    for (int g = 0; g < 3; g++) begin
      int c, f;
      bit fin, on;
      logic [7:0] ea;
      rec_t r;
      if (!reset) begin
        mact[g] = 0;
        sb[g].delete();
        chk("rst_strobes", g, {ad_v[g], cs_v[g], wr_v[g], rd_v[g]}, 4'hF);
        chk("rst_adout", g, ad_out_v[g], 8'hFF);
        chk("rst_flags", g, {adoe_v[g], busy_v[g], valid_v[g], done_v[g]}, 0);
        chk("rst_dout", g, {dout_v[g], idx_v[g]}, 0);
        continue;
      end
      fin = 0;
      if (mact[g]) begin
        mn[g]++;
        if (mn[g] == 32 * NR[g]) begin
          mact[g] = 0;
          fin = 1;
        end
      end else if (start_v[g]) begin
        mact[g] = 1;
        mn[g] = 0;
        for (int i = 0; i < NR[g]; i++) sb[g].push_back('{4'(i), rtc(BA[g] + 8'(i))});
      end
      on = mact[g];
      c = mn[g] % 32;
      f = mn[g] / 32;
      ea = BA[g] + 8'(f);
      chk("ad", g, ad_v[g], !(on && c >= 2 && c <= 11));
      chk("cs", g, cs_v[g], !(on && ((c >= 3 && c <= 10) || (c >= 23 && c <= 30))));
      chk("wr", g, wr_v[g], !(on && c >= 4 && c <= 9));
      chk("rd", g, rd_v[g], !(on && c >= 24 && c <= 29));
      chk("adoe", g, adoe_v[g], on && c >= 5 && c <= 13);
      chk("adout", g, ad_out_v[g], (on && c >= 5 && c <= 13) ? ea : 8'hFF);
      chk("busy", g, busy_v[g], on);
      chk("done", g, done_v[g], fin);
      chk("valid", g, valid_v[g], on && c == 29);
      chk("rd_wr_overlap", g, !rd_v[g] && !wr_v[g], 0);
      chk("oe_during_rd", g, !rd_v[g] && adoe_v[g], 0);
      if (done_v[g]) done_cnt[g]++;
      if (valid_v[g]) begin
        if (sb[g].size() == 0) chk("sb_empty", g, 1, 0);
        else begin
          r = sb[g].pop_front();
          chk("dout_idx", g, idx_v[g], r.idx);
          chk("dout", g, dout_v[g], r.data);
        end
      end
    end
  end

  initial begin
    step_t steps [5];
    int base [3];
    steps[0] = '{3'b111, 1, 0, 110, {4'd1, 4'd1, 4'd1}};
    steps[1] = '{3'b001, 150, 0, 260, {4'd0, 4'd0, 4'd2}};
    steps[2] = '{3'b001, 1, 40, 110, {4'd0, 4'd0, 4'd1}};
    steps[3] = '{3'b100, 1, 0, 40, {4'd1, 4'd0, 4'd0}};
    steps[4] = '{3'b010, 1, 0, 110, {4'd0, 4'd1, 4'd0}};
    for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int s = 0; s < 5; s++) begin
      for (int g = 0; g < 3; g++) base[g] = done_cnt[g];
      for (int k = 0; k < steps[s].total; k++) begin
        @(negedge clock);
        for (int g = 0; g < 3; g++)
          start_v[g] = steps[s].mask[g] && (k < steps[s].len || (steps[s].rp != 0 && k == steps[s].rp));
      end
      @(negedge clock);
      for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
      repeat (2) @(negedge clock);
      for (int g = 0; g < 3; g++) chk("step_dones", g, done_cnt[g] - base[g], int'(steps[s].exp_done[4*g +: 4]));
    end
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (57) @(posedge clock);
    #2;
    chk("pre_abort_rd", 0, rd_v[0], 0);
    base[0] = done_cnt[0];
    reset = 1'b0;
    #1;
    chk("abort_strobes", 0, {ad_v[0], cs_v[0], wr_v[0], rd_v[0]}, 4'hF);
    chk("abort_oe_busy", 0, {adoe_v[0], busy_v[0]}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("abort_no_done", 0, done_cnt[0] - base[0], 0);
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    repeat (110) @(negedge clock);
    chk("restart_done", 0, done_cnt[0] - base[0], 1);
    for (int g = 0; g < 3; g++) chk("sb_drained", g, sb[g].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
